sub_serial: RTL

//  Bit-serial two's-complement subtractor: out = a - b, one bit per clock, LSB first.

---
 rtl/sub_serial_pkg.sv | 21 ++
 rtl/sub_serial_full_adder.sv | 13 +
 rtl/sub_serial.sv | 125 ++++++++++++
 3 files changed

// File: rtl/sub_serial_pkg.sv
// sub_serial_pkg: FSM state encodings and the saturation pattern helper for sub_serial.
package sub_serial_pkg;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = S_IDLE,
        RUN  = S_RUN,
        DONE = S_DONE
    } state_t;

    // Most-negative pattern (100..0) when neg, else most-positive (011..1), for a w-bit word.
    function automatic logic [63:0] sat_val(input logic neg, input int w);
        logic [63:0] m;
        m = 64'd1 << (w - 1);
        return neg ? m : m - 64'd1;
    endfunction

endpackage

// File: rtl/sub_serial_full_adder.sv
// full_adder: single-bit full adder used as the serial bit slice.
module full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);

    assign s_o = a_i ^ b_i ^ c_i;
    assign c_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);

endmodule

// File: rtl/sub_serial.sv
// sub_serial: bit-serial two's-complement subtractor out = a - b, LSB first, start/done handshake.
// Optional saturation on signed overflow when SUB_SERIAL_SAT_EN is defined.
module sub_serial
    import sub_serial_pkg::*;
#(
    parameter int width = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [width-1:0] a,
    input  logic [width-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [width-1:0] out,
    output logic             ovf
);

    localparam int CW = $clog2(width);

    state_t           state_q, state_d;
    logic [width-1:0] a_sh_q, a_sh_d, b_sh_q, b_sh_d;
    logic [width-1:0] res_q, res_d, out_q, out_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             c_q, c_d, ovf_q, ovf_d;
    logic             s, co, last, ovf_n;
    logic [width-1:0] res_n, fin;

    // Subtraction as a + ~b + 1: invert the subtrahend bit, carry seeded to 1 on start.
    full_adder u_fa (
        .a_i(a_sh_q[0]),
        .b_i(~b_sh_q[0]),
        .c_i(c_q),
        .s_o(s),
        .c_o(co)
    );

    assign last  = cnt_q == CW'(width - 1);
    assign res_n = {s, res_q[width-1:1]};
    assign ovf_n = co ^ c_q;

`ifdef SUB_SERIAL_SAT_EN
    logic        a_msb_q, a_msb_d;
    logic [63:0] sat_full;
    assign sat_full = sat_val(a_msb_q, width);
    assign fin      = ovf_n ? sat_full[width-1:0] : res_n;
`else
    assign fin = res_n;
`endif

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        res_d   = res_q;
        out_d   = out_q;
        cnt_d   = cnt_q;
        c_d     = c_q;
        ovf_d   = ovf_q;
`ifdef SUB_SERIAL_SAT_EN
        a_msb_d = a_msb_q;
`endif
        unique case (state_q)
            IDLE: if (start) begin
                a_sh_d  = a;
                b_sh_d  = b;
                res_d   = '0;
                c_d     = 1'b1;
                cnt_d   = '0;
                state_d = RUN;
`ifdef SUB_SERIAL_SAT_EN
                a_msb_d = a[width-1];
`endif
            end
            RUN: begin
                a_sh_d = {1'b0, a_sh_q[width-1:1]};
                b_sh_d = {1'b0, b_sh_q[width-1:1]};
                res_d  = res_n;
                c_d    = co;
                cnt_d  = cnt_q + 1'b1;
                if (last) begin
                    out_d   = fin;
                    ovf_d   = ovf_n;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            out_q   <= '0;
            cnt_q   <= '0;
            c_q     <= 1'b0;
            ovf_q   <= 1'b0;
`ifdef SUB_SERIAL_SAT_EN
            a_msb_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            res_q   <= res_d;
            out_q   <= out_d;
            cnt_q   <= cnt_d;
            c_q     <= c_d;
            ovf_q   <= ovf_d;
`ifdef SUB_SERIAL_SAT_EN
            a_msb_q <= a_msb_d;
`endif
        end
    end

    assign busy = state_q != IDLE;
    assign done = state_q == DONE;
    assign out  = out_q;
    assign ovf  = ovf_q;

endmodule
